mul_ctrl: RTL and testbench

- Issue/sequencing controller between the EX stage and the 64-bit radix-4 Booth multiplier (muler).
- Decodes RV64M multiply ops and drives the multiplier's in_valid, mulw and mul_signed encoding and operands.
- Captures the multiplier's one-cycle out_valid result, selects and sign-extends the requested half, and holds it under a valid/ready response handshake.
- Handles pipeline flush and a hung-multiplier watchdog.

---
 rtl/mul_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mul_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
// ============================================================================
// Module   : mul_ctrl
// Purpose  : Issue/sequencing controller between EX and the radix-4 Booth
//            multiplier (muler): decode, issue, capture, respond, flush and
//            watchdog.
// Option   : MULCTL_ZERO_BYPASS_EN - zero operand answers without the muler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_ctrl #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic        mul_in_valid,
  output logic        mul_flush,
  output logic        mul_mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] mul_multiplicand,
  output logic [63:0] mul_multiplier,
  input  logic        mul_out_ready,
  input  logic        mul_out_valid,
  input  logic [63:0] mul_result_hi,
  input  logic [63:0] mul_result_lo
);

  if ((TIMEOUT_CYCLES < 40) || (TIMEOUT_CYCLES > 255)) begin : g_param_check
    $error("mul_ctrl: TIMEOUT_CYCLES must be within 40..255");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] src1_q, src1_d;
  logic [63:0] src2_q, src2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        op_reserved;
  logic        zero_src;
  logic        cnt_expired;
  logic [63:0] result_sel;

  assign accept      = req_valid & (state_q == ST_IDLE) & ~flush;
  assign op_reserved = (req_op > OP_MULW);
  assign cnt_expired = (cnt_q == C_CNT_LAST);

`ifdef MULCTL_ZERO_BYPASS_EN
  assign zero_src = (req_src1 == 64'd0) | (req_src2 == 64'd0);
`else
  assign zero_src = 1'b0;
`endif

  // Reserved ops never reach WAIT, so the default arm only serves the high-half ops.
  always_comb begin
    result_sel = mul_result_hi;
    case (op_q)
      OP_MUL:  result_sel = mul_result_lo;
      OP_MULW: result_sel = {{32{mul_result_lo[31]}}, mul_result_lo[31:0]};
      default: result_sel = mul_result_hi;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      src1_q      <= 64'd0;
      src2_q      <= 64'd0;
      cnt_q       <= 8'd0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d        = req_op;
          src1_d      = req_src1;
          src2_d      = req_src2;
          resp_data_d = 64'd0;
          resp_err_d  = 1'b0;
          state_d     = (op_reserved | zero_src) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_out_ready) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) begin
          // A result arriving with the flush closes the op; otherwise drain it.
          state_d = mul_out_valid ? ST_IDLE : ST_DRAIN;
          cnt_d   = 8'd0;
        end else if (mul_out_valid) begin
          state_d     = ST_DONE;
          resp_data_d = result_sel;
          resp_err_d  = 1'b0;
        end else if (cnt_expired) begin
          state_d     = ST_DONE;
          resp_data_d = 64'd0;
          resp_err_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (mul_out_valid || cnt_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state_q == ST_IDLE) & ~flush;
    busy             = (state_q != ST_IDLE);
    resp_valid       = (state_q == ST_DONE);
    resp_err         = (state_q == ST_DONE) & resp_err_q;
    resp_data        = (state_q == ST_DONE) ? resp_data_q : 64'd0;
    mul_in_valid     = (state_q == ST_ISSUE) & mul_out_ready & ~flush;
    mul_flush        = (state_q == ST_WAIT) & ~mul_out_valid & (flush | cnt_expired);
    mul_mulw         = (op_q == OP_MULW);
    mul_multiplicand = src1_q;
    mul_multiplier   = src2_q;
    mul_signed       = 2'b00;
    case (op_q)
      OP_MULH:   mul_signed = 2'b11;
      OP_MULHSU: mul_signed = 2'b10;
      default:   mul_signed = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_ctrl.sv
// ============================================================================
// Module   : tb_mul_ctrl
// Purpose  : Directed bench for mul_ctrl with a behavioural muler stand-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_ctrl;

  localparam int TO = 63;
`ifdef MULCTL_ZERO_BYPASS_EN
  localparam int BYP_PULSES = 0;
`else
  localparam int BYP_PULSES = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [63:0] req_src1 = 64'd0;
  logic [63:0] req_src2 = 64'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        mul_in_valid;
  logic        mul_flush;
  logic        mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_out_ready = 1'b1;
  logic        mul_out_valid = 1'b0;
  logic [63:0] mul_result_hi = 64'd0;
  logic [63:0] mul_result_lo = 64'd0;

  always #5 clock = ~clock;

  mul_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy),
    .mul_in_valid(mul_in_valid), .mul_flush(mul_flush), .mul_mulw(mul_mulw),
    .mul_signed(mul_signed), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_out_ready(mul_out_ready),
    .mul_out_valid(mul_out_valid), .mul_result_hi(mul_result_hi),
    .mul_result_lo(mul_result_lo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Muler stand-in: fixed latency, ignores flush, garbage when not valid.
  int           lat  = 1;
  bit           hang = 1'b0;
  int           pend = 0;
  logic [127:0] pend_prod;
  logic [127:0] ea, eb;
  int           inv_cnt = 0;
  int           flush_cnt = 0;
  logic [1:0]   cap_signed = 2'b00;
  logic         cap_mulw = 1'b0;
  logic [63:0]  cap_a = 64'd0, cap_b = 64'd0;

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      pend          = 0;
      mul_out_valid = 1'b0;
    end else begin
      mul_out_valid = 1'b0;
      mul_result_hi = 64'hDEAD_BEEF_DEAD_BEEF;
      mul_result_lo = 64'hBAAD_F00D_BAAD_F00D;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !hang) begin
          mul_out_valid = 1'b1;
          mul_result_hi = pend_prod[127:64];
          mul_result_lo = pend_prod[63:0];
        end
      end
      if (mul_in_valid) begin
        inv_cnt++;
        cap_signed = mul_signed;
        cap_mulw   = mul_mulw;
        cap_a      = mul_multiplicand;
        cap_b      = mul_multiplier;
        ea = mul_signed[1] ? {{64{mul_multiplicand[63]}}, mul_multiplicand} : {64'd0, mul_multiplicand};
        eb = mul_signed[0] ? {{64{mul_multiplier[63]}}, mul_multiplier} : {64'd0, mul_multiplier};
        pend_prod = ea * eb;
        pend = lat;
      end
      if (mul_flush) flush_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input string nm);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    #1;
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    req_src1  = 64'hA5A5_A5A5_A5A5_A5A5;
    req_src2  = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic wait_resp(input int max, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume(input string nm);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(resp_valid), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_data;
    logic [1:0]  exp_sgn;
    logic        exp_mulw;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int cyc, base_inv, base_fl;
    bit saw_valid;
    logic [63:0] held;

    vecs[0] = '{3'd0, 64'd3, 64'd5, 64'h0000_0000_0000_000F, 2'b00, 1'b0, 1};
    vecs[1] = '{3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, 1};
    vecs[2] = '{3'd1, '1, '1, 64'h0000_0000_0000_0000, 2'b11, 1'b0, 1};
    vecs[3] = '{3'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1};
    vecs[4] = '{3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b1, 1};
    vecs[5] = '{3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 2'b00, 1'b0, 1};
    vecs[6] = '{3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 2'b00, 1'b0, 1};
    vecs[7] = '{3'd0, 64'd0, 64'd5, 64'd0, 2'b00, 1'b0, BYP_PULSES};
    vecs[8] = '{3'd4, 64'h1234_5678_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 2'b00, 1'b1, 1};
    vecs[9] = '{3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h4000_0000_0000_0000, 2'b11, 1'b0, 1};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_in_valid", 64'(mul_in_valid), 64'd0);
    chk("rst_mul_flush", 64'(mul_flush), 64'd0);
    chk("rst_operands", mul_multiplicand | mul_multiplier, 64'd0);
    chk("rst_mode", {61'd0, mul_mulw, mul_signed}, 64'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      base_inv = inv_cnt;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("v%0d", i));
      wait_resp(20, cyc);
      chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'd1);
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), 64'(resp_err), 64'd0);
      chk($sformatf("v%0d_pulses", i), 64'(inv_cnt - base_inv), 64'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses == 1) begin
        chk($sformatf("v%0d_signed", i), 64'(cap_signed), 64'(vecs[i].exp_sgn));
        chk($sformatf("v%0d_mulw", i), 64'(cap_mulw), 64'(vecs[i].exp_mulw));
        chk($sformatf("v%0d_opa", i), cap_a, vecs[i].a);
        chk($sformatf("v%0d_opb", i), cap_b, vecs[i].b);
      end
      if (i == 0) begin
        held = resp_data;
        for (int k = 0; k < 10; k++) begin
          tick();
          chk("hold_valid", 64'(resp_valid), 64'd1);
          chk("hold_data", resp_data, held);
        end
        chk("hold_pulses", 64'(inv_cnt - base_inv), 64'd1);
      end
      consume($sformatf("v%0d", i));
    end

    // Multiplier not ready: issue waits, then exactly one pulse
    mul_out_ready = 1'b0;
    base_inv = inv_cnt;
    issue(3'd0, 64'd4, 64'd4, "stall");
    repeat (3) tick();
    chk("stall_no_pulse", 64'(inv_cnt - base_inv), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    mul_out_ready = 1'b1;
    wait_resp(20, cyc);
    chk("stall_pulses", 64'(inv_cnt - base_inv), 64'd1);
    chk("stall_data", resp_data, 64'h10);
    consume("stall");

    // Flush in WAIT, late result dropped in DRAIN
    lat = 10;
    base_fl = flush_cnt;
    issue(3'd0, 64'd9, 64'd9, "drain");
    repeat (4) tick();
    flush = 1'b1;
    #1;
    chk("drain_mul_flush", 64'(mul_flush), 64'd1);
    tick();
    flush = 1'b0;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_req_ready", 64'(req_ready), 64'd0);
    saw_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 15) begin
      tick();
      cyc++;
      saw_valid |= resp_valid;
    end
    chk("drain_exit", 64'(busy), 64'd0);
    chk("drain_no_resp", 64'(saw_valid), 64'd0);
    chk("drain_flush_pulses", 64'(flush_cnt - base_fl), 64'd1);
    lat = 1;
    issue(3'd0, 64'd7, 64'd6, "after_drain");
    wait_resp(20, cyc);
    chk("after_drain_data", resp_data, 64'h2A);
    consume("after_drain");

    // Watchdog
    hang = 1'b1;
    base_fl = flush_cnt;
    issue(3'd0, 64'd1, 64'd1, "wdog");
    tick();
    wait_resp(200, cyc);
    chk("wdog_latency", 64'(cyc), 64'(TO));
    chk("wdog_valid", 64'(resp_valid), 64'd1);
    chk("wdog_err", 64'(resp_err), 64'd1);
    chk("wdog_data", resp_data, 64'd0);
    chk("wdog_flush_pulses", 64'(flush_cnt - base_fl), 64'd1);
    consume("wdog");
    hang = 1'b0;

    // Reserved op
    base_inv = inv_cnt;
    issue(3'd6, 64'd3, 64'd3, "rsvd");
    chk("rsvd_valid", 64'(resp_valid), 64'd1);
    chk("rsvd_data", resp_data, 64'd0);
    chk("rsvd_err", 64'(resp_err), 64'd0);
    chk("rsvd_pulses", 64'(inv_cnt - base_inv), 64'd0);
    consume("rsvd");

    // Flush together with a request
    base_inv = inv_cnt;
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = 3'd0;
    req_src1 = 64'd2;
    req_src2 = 64'd2;
    #1;
    chk("flreq_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flreq_idle", 64'(busy), 64'd0);
    tick();
    chk("flreq_no_pulse", 64'(inv_cnt - base_inv), 64'd0);

    // Flush beats a same-cycle consume in DONE
    issue(3'd0, 64'd2, 64'd3, "fldone");
    wait_resp(20, cyc);
    chk("fldone_data", resp_data, 64'd6);
    flush = 1'b1;
    resp_ready = 1'b1;
    tick();
    flush = 1'b0;
    resp_ready = 1'b0;
    chk("fldone_valid", 64'(resp_valid), 64'd0);
    chk("fldone_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation
    lat = 10;
    issue(3'd0, 64'd5, 64'd5, "arst");
    tick();
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_valid", 64'(mul_in_valid), 64'd0);
    tick();
    reset = 1'b1;
    lat = 1;
    tick();
    issue(3'd0, 64'd3, 64'd3, "arst_after");
    wait_resp(20, cyc);
    chk("arst_after_data", resp_data, 64'd9);
    consume("arst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
